// File: rtl/xc_mp_arith_seq_if.sv
// Handshake bundle between the limb-fetch/writeback engines and the
// multi-precision add/subtract sequencer.
interface xc_mp_arith_seq_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned LW   = 5
);

  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_op;
  logic [LW-1:0]   cmd_len;

  logic            opnd_valid;
  logic            opnd_ready;
  logic [XLEN-1:0] opnd_a;
  logic [XLEN-1:0] opnd_b;

  logic            res_valid;
  logic            res_ready;
  logic [XLEN-1:0] res_data;
  logic            res_last;

  logic            done_valid;
  logic            done_flag;
  logic            busy;

  // Requester side: issues commands and operands, consumes results
  modport master (
    output cmd_valid, cmd_op, cmd_len,
    output opnd_valid, opnd_a, opnd_b,
    output res_ready,
    input  cmd_ready, opnd_ready,
    input  res_valid, res_data, res_last,
    input  done_valid, done_flag, busy
  );

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_op, cmd_len,
    input  opnd_valid, opnd_a, opnd_b,
    input  res_ready,
    output cmd_ready, opnd_ready,
    output res_valid, res_data, res_last,
    output done_valid, done_flag, busy
  );

endinterface

// File: rtl/xc_mp_arith_seq.sv
// Multi-precision add/subtract sequencer: takes one command, walks operand
// limb pairs LS-first through an msub/madd limb step, chains the carry or
// borrow, streams one result limb per pair and finally reports the carry.
module xc_mp_arith_seq #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned MAX_LIMBS = 16,
  parameter int unsigned LW        = $clog2(MAX_LIMBS) + 1
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  xc_mp_arith_seq_if.slave  bus
);

  localparam int unsigned RW = XLEN + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            op_q, op_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic            res_valid_q, res_valid_d;
  logic [XLEN-1:0] res_data_q, res_data_d;
  logic            res_last_q, res_last_d;
  logic            done_valid_q, done_valid_d;
  logic            done_flag_q, done_flag_d;

  logic            cmd_ready_c;
  logic            opnd_ready_c;
  logic            opnd_hs_c;
  logic            res_hs_c;
  logic            is_last_c;
  logic [LW-1:0]   len_sat_c;
  logic [RW-1:0]   ext_a_c, ext_b_c, ext_cy_c, step_c;

  // Limb step: zero-extended so the top bit is carry-out (add) or borrow (sub)
  always_comb begin
    ext_a_c  = {1'b0, bus.opnd_a};
    ext_b_c  = {1'b0, bus.opnd_b};
    ext_cy_c = RW'(carry_q);
    if (op_q) begin
      step_c = ext_a_c + ext_b_c + ext_cy_c;
    end else begin
      step_c = ext_a_c - ext_b_c - ext_cy_c;
    end
  end

  // Next-state, datapath update and handshake decode
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    carry_d      = carry_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_last_d   = res_last_q;
    done_valid_d = 1'b0;
    done_flag_d  = 1'b0;

    len_sat_c    = (bus.cmd_len > LW'(MAX_LIMBS)) ? LW'(MAX_LIMBS) : bus.cmd_len;
    cmd_ready_c  = (state_q == S_IDLE);
    // Single-entry result register: accept a new pair if it is empty or draining now
    opnd_ready_c = (state_q == S_RUN) && (!res_valid_q || bus.res_ready);
    opnd_hs_c    = bus.opnd_valid && opnd_ready_c;
    res_hs_c     = res_valid_q && bus.res_ready;
    is_last_c    = (cnt_q == (len_q - LW'(1)));

    if (res_hs_c) begin
      res_valid_d = 1'b0;
    end
    if (opnd_hs_c) begin
      res_valid_d = 1'b1;
      res_data_d  = step_c[XLEN-1:0];
      res_last_d  = is_last_c;
      carry_d     = step_c[XLEN];
      cnt_d       = cnt_q + LW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d    = bus.cmd_op;
          len_d   = len_sat_c;
          cnt_d   = '0;
          carry_d = 1'b0;
          state_d = (len_sat_c == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (opnd_hs_c && is_last_c) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (res_hs_c) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_valid_d = 1'b1;
        done_flag_d  = carry_q;
        state_d      = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q      <= S_IDLE;
      op_q         <= 1'b0;
      len_q        <= '0;
      cnt_q        <= '0;
      carry_q      <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_last_q   <= 1'b0;
      done_valid_q <= 1'b0;
      done_flag_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      carry_q      <= carry_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_last_q   <= res_last_d;
      done_valid_q <= done_valid_d;
      done_flag_q  <= done_flag_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready_c;
  assign bus.opnd_ready = opnd_ready_c;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_last   = res_last_q;
  assign bus.done_valid = done_valid_q;
  assign bus.done_flag  = done_flag_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_xc_mp_arith_seq.sv
// Bench for the multi-precision add/subtract sequencer.
module tb_xc_mp_arith_seq;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned MAX_LIMBS = 16;
  localparam int unsigned LW        = 5;

  logic g_clk;
  logic g_resetn;

  xc_mp_arith_seq_if #(.XLEN(XLEN), .LW(LW)) bus ();

  xc_mp_arith_seq #(.XLEN(XLEN), .MAX_LIMBS(MAX_LIMBS), .LW(LW)) dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .bus      (bus)
  );

  always #5 g_clk = ~g_clk;

  int checks;
  int errors;

  logic [31:0] a_arr   [32];
  logic [31:0] b_arr   [32];
  logic [31:0] exp_arr [32];
  bit          exp_flag;

  logic [31:0] got_q    [$];
  bit          got_last [$];
  bit          done_seen, done_flg, done_after, timeout;
  int          done_lat, viol_stable, viol_oprdy, extra_acc;

  // Reference: big-number add/sub one limb at a time with 64-bit integers
  task automatic model(input bit op, input int n);
    longint c, t, ta, tb;
    c = 0;
    for (int i = 0; i < n; i++) begin
      ta = {32'h0, a_arr[i]};
      tb = {32'h0, b_arr[i]};
      if (op) begin
        t = ta + tb + c;
        c = (t >= 64'sh1_0000_0000) ? 1 : 0;
      end else begin
        t = ta - tb - c;
        c = (t < 0) ? 1 : 0;
      end
      exp_arr[i] = t[31:0];
    end
    exp_flag = (c != 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      default: return 32'($urandom);
    endcase
  endfunction

  // Drive one command end to end and record everything the DUT produced
  task automatic run_cmd(input bit op, input int len_field, input int n,
                         input int rdy_mode, input int vld_mode);
    int idx, cyc;
    bit prev_stall;
    logic [31:0] prev;
    idx = 0; cyc = -1; prev_stall = 0; prev = '0;
    got_q.delete(); got_last.delete();
    done_seen = 0; done_flg = 0; done_after = 0; done_lat = -1;
    viol_stable = 0; viol_oprdy = 0; extra_acc = 0; timeout = 0;
    @(negedge g_clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_len   = LW'(len_field);
    @(posedge g_clk);
    #1;
    bus.cmd_valid = 1'b0;
    while (!done_seen && cyc < 600) begin
      @(negedge g_clk);
      cyc++;
      if (bus.done_valid) begin
        done_seen = 1;
        done_lat  = cyc;
        done_flg  = bus.done_flag;
      end else begin
        if (prev_stall && (bus.res_valid !== 1'b1 || bus.res_data !== prev)) viol_stable++;
        case (rdy_mode)
          0:       bus.res_ready = 1'b1;
          1:       bus.res_ready = (cyc % 2 == 0);
          default: bus.res_ready = 1'($urandom_range(0, 1));
        endcase
        if (idx < n) begin
          bus.opnd_valid = (vld_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
          bus.opnd_a     = a_arr[idx];
          bus.opnd_b     = b_arr[idx];
        end else begin
          bus.opnd_valid = 1'b1;
          bus.opnd_a     = 32'($urandom);
          bus.opnd_b     = 32'($urandom);
        end
        #1;
        if (bus.res_valid && !bus.res_ready && bus.opnd_ready) viol_oprdy++;
        if (bus.opnd_valid && bus.opnd_ready) begin
          if (idx < n) idx++;
          else extra_acc++;
        end
        if (bus.res_valid && bus.res_ready) begin
          got_q.push_back(bus.res_data);
          got_last.push_back(bus.res_last);
        end
        prev_stall = bus.res_valid && !bus.res_ready;
        prev       = bus.res_data;
      end
    end
    timeout = !done_seen;
    bus.opnd_valid = 1'b0;
    bus.res_ready  = 1'b0;
    @(negedge g_clk);
    done_after = bus.done_valid;
  endtask

  task automatic test_reset();
    bus.opnd_valid = 1'b1;
    bus.res_ready  = 1'b1;
    #1;
    checks++;
    if ({bus.res_valid, bus.res_last, bus.done_valid, bus.done_flag, bus.busy, bus.opnd_ready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b want=000000", {bus.res_valid, bus.res_last, bus.done_valid, bus.done_flag, bus.busy, bus.opnd_ready});
    end
    checks++;
    if (bus.res_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h want=0", bus.res_data); end
    repeat (2) @(posedge g_clk);
    @(negedge g_clk);
    g_resetn = 1'b1;
    bus.opnd_valid = 1'b0;
    bus.res_ready  = 1'b0;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b want=1", bus.cmd_ready); end
  endtask

  task automatic test_sub_single();
    a_arr[0] = 32'd5; b_arr[0] = 32'd3;
    run_cmd(1'b0, 1, 1, 0, 0);
    checks++;
    if (got_q.size() !== 1 || got_q[0] !== 32'd2 || got_last[0] !== 1'b1) begin
      errors++; $display("FAIL sub1_res n=%0d got=%h want=1 limb 00000002 last", got_q.size(), got_q[0]);
    end
    checks++;
    if (done_seen !== 1'b1 || done_flg !== 1'b0) begin errors++; $display("FAIL sub1_done seen=%0d flag=%0d want 1/0", done_seen, done_flg); end
    checks++;
    if (done_lat !== 3) begin errors++; $display("FAIL sub1_latency got=%0d want=3", done_lat); end
    checks++;
    if (done_after !== 1'b0) begin errors++; $display("FAIL sub1_pulse_width done still high"); end
    a_arr[0] = 32'd0; b_arr[0] = 32'd1;
    run_cmd(1'b0, 1, 1, 0, 0);
    checks++;
    if (got_q.size() !== 1 || got_q[0] !== 32'hFFFF_FFFF || done_flg !== 1'b1) begin
      errors++; $display("FAIL sub1_borrow got=%h flag=%0d want=ffffffff flag=1", got_q[0], done_flg);
    end
  endtask

  task automatic test_two_limb();
    a_arr[0] = 32'd0; a_arr[1] = 32'd1; b_arr[0] = 32'd1; b_arr[1] = 32'd0;
    run_cmd(1'b0, 2, 2, 0, 0);
    checks++;
    if (got_q.size() !== 2 || got_q[0] !== 32'hFFFF_FFFF || got_q[1] !== 32'h0 ||
        got_last[0] !== 1'b0 || got_last[1] !== 1'b1 || done_flg !== 1'b0) begin
      errors++; $display("FAIL sub2 got=%h,%h flag=%0d want=ffffffff,00000000 flag=0", got_q[0], got_q[1], done_flg);
    end
    checks++;
    if (done_lat !== 4) begin errors++; $display("FAIL sub2_latency got=%0d want=4", done_lat); end
    a_arr[0] = 32'hFFFF_FFFF; a_arr[1] = 32'h0; b_arr[0] = 32'd1; b_arr[1] = 32'h0;
    run_cmd(1'b1, 2, 2, 0, 0);
    checks++;
    if (got_q.size() !== 2 || got_q[0] !== 32'h0 || got_q[1] !== 32'd1 || done_flg !== 1'b0) begin
      errors++; $display("FAIL add2 got=%h,%h flag=%0d want=00000000,00000001 flag=0", got_q[0], got_q[1], done_flg);
    end
    a_arr[1] = 32'hFFFF_FFFF; b_arr[1] = 32'hFFFF_FFFF;
    run_cmd(1'b1, 2, 2, 0, 0);
    checks++;
    if (got_q.size() !== 2 || got_q[0] !== 32'h0 || got_q[1] !== 32'hFFFF_FFFF || done_flg !== 1'b1) begin
      errors++; $display("FAIL add2_ones got=%h,%h flag=%0d want=00000000,ffffffff flag=1", got_q[0], got_q[1], done_flg);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) begin a_arr[i] = pick(); b_arr[i] = pick(); end
    model(1'b0, 4);
    run_cmd(1'b0, 4, 4, 1, 0);
    checks++;
    if (got_q.size() !== 4) begin errors++; $display("FAIL stall_count got=%0d want=4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_q[i] !== exp_arr[i] || got_last[i] !== (i == 3)) begin
        errors++; $display("FAIL stall_limb%0d got=%h last=%0d want=%h", i, got_q[i], got_last[i], exp_arr[i]);
      end
    end
    checks++;
    if (viol_oprdy !== 0 || viol_stable !== 0) begin
      errors++; $display("FAIL stall_backpressure opnd_ready_viol=%0d unstable=%0d want 0/0", viol_oprdy, viol_stable);
    end
    checks++;
    if (done_flg !== exp_flag) begin errors++; $display("FAIL stall_flag got=%0d want=%0d", done_flg, exp_flag); end
  endtask

  task automatic test_len_zero();
    run_cmd(1'b1, 0, 0, 0, 0);
    checks++;
    if (done_seen !== 1'b1 || done_lat !== 1 || done_flg !== 1'b0) begin
      errors++; $display("FAIL len0_done seen=%0d lat=%0d flag=%0d want 1/1/0", done_seen, done_lat, done_flg);
    end
    checks++;
    if (got_q.size() !== 0 || extra_acc !== 0) begin
      errors++; $display("FAIL len0_no_operands results=%0d accepted=%0d want 0/0", got_q.size(), extra_acc);
    end
  endtask

  task automatic test_mid_reset();
    int idx, bound, pulses;
    a_arr[0] = 32'd0; b_arr[0] = 32'd1; a_arr[1] = 32'd7; b_arr[1] = 32'd2;
    idx = 0; bound = 0; pulses = 0;
    @(negedge g_clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 1'b0; bus.cmd_len = LW'(4);
    @(posedge g_clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    while (idx < 2 && bound < 20) begin
      @(negedge g_clk);
      bound++;
      bus.opnd_valid = 1'b1; bus.opnd_a = a_arr[idx]; bus.opnd_b = b_arr[idx];
      #1;
      if (bus.opnd_ready) idx++;
    end
    @(posedge g_clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_busy busy=%b cmd_ready=%b want 1/0", bus.busy, bus.cmd_ready);
    end
    @(negedge g_clk);
    g_resetn = 1'b0;
    #1;
    checks++;
    if ({bus.res_valid, bus.res_last, bus.done_valid, bus.done_flag, bus.busy, bus.opnd_ready} !== 6'b0 ||
        bus.res_data !== 32'h0) begin
      errors++; $display("FAIL midrst_outputs ctrl=%b data=%h want all zero",
        {bus.res_valid, bus.res_last, bus.done_valid, bus.done_flag, bus.busy, bus.opnd_ready}, bus.res_data);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge g_clk);
      if (bus.done_valid) pulses++;
    end
    g_resetn = 1'b1;
    bus.opnd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge g_clk);
      if (bus.done_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL midrst_no_done got=%0d pulses want=0", pulses); end
    a_arr[0] = 32'd5; b_arr[0] = 32'd5;
    run_cmd(1'b0, 1, 1, 0, 0);
    checks++;
    if (got_q.size() !== 1 || got_q[0] !== 32'h0 || done_flg !== 1'b0 || done_lat !== 3) begin
      errors++; $display("FAIL midrst_followup got=%h flag=%0d lat=%0d want=00000000 flag=0 lat=3", got_q[0], done_flg, done_lat);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 16; i++) begin a_arr[i] = pick(); b_arr[i] = pick(); end
    model(1'b1, 16);
    run_cmd(1'b1, 20, 16, 0, 0);
    checks++;
    if (got_q.size() !== 16 || extra_acc !== 0 || done_lat !== 18) begin
      errors++; $display("FAIL sat_shape results=%0d extra=%0d lat=%0d want 16/0/18", got_q.size(), extra_acc, done_lat);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got_q[i] !== exp_arr[i] || got_last[i] !== (i == 15)) begin
        errors++; $display("FAIL sat_limb%0d got=%h last=%0d want=%h", i, got_q[i], got_last[i], exp_arr[i]);
      end
    end
    checks++;
    if (done_flg !== exp_flag) begin errors++; $display("FAIL sat_flag got=%0d want=%0d", done_flg, exp_flag); end
  endtask

  task automatic test_random();
    bit op;
    int n;
    for (int k = 0; k < 25; k++) begin
      op = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 16);
      for (int i = 0; i < n; i++) begin a_arr[i] = pick(); b_arr[i] = pick(); end
      model(op, n);
      run_cmd(op, n, n, 2, 1);
      checks++;
      if (timeout || got_q.size() !== n || extra_acc !== 0) begin
        errors++; $display("FAIL rand%0d_shape timeout=%0d results=%0d extra=%0d want 0/%0d/0", k, timeout, got_q.size(), extra_acc, n);
      end
      for (int i = 0; i < n; i++) begin
        checks++;
        if (got_q[i] !== exp_arr[i] || got_last[i] !== (i == n - 1)) begin
          errors++; $display("FAIL rand%0d_limb%0d got=%h last=%0d want=%h", k, i, got_q[i], got_last[i], exp_arr[i]);
        end
      end
      checks++;
      if (done_flg !== exp_flag || viol_oprdy !== 0 || viol_stable !== 0 || done_after !== 1'b0) begin
        errors++; $display("FAIL rand%0d_flag flag=%0d want=%0d oprdy_viol=%0d unstable=%0d", k, done_flg, exp_flag, viol_oprdy, viol_stable);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    for (int k = 0; k < 6; k++) begin
      n = (k % 2 == 0) ? 3 : 1;
      for (int i = 0; i < n; i++) begin
        a_arr[i] = (k % 2 == 0) ? 32'hFFFF_FFFF : 32'h0;
        b_arr[i] = (k % 2 == 0) ? 32'hFFFF_FFFF : 32'h0;
      end
      model(1'b1, n);
      run_cmd(1'b1, n, n, 0, 0);
      checks++;
      if (got_q.size() !== n || got_q[n-1] !== exp_arr[n-1] || done_flg !== exp_flag || done_lat !== n + 2) begin
        errors++; $display("FAIL b2b%0d top=%h flag=%0d lat=%0d want=%h flag=%0d lat=%0d",
          k, got_q[n-1], done_flg, done_lat, exp_arr[n-1], exp_flag, n + 2);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    g_clk = 1'b0;
    g_resetn = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0; bus.cmd_len = '0;
    bus.opnd_valid = 1'b0; bus.opnd_a = '0; bus.opnd_b = '0;
    bus.res_ready = 1'b0;
    #2;
    g_resetn = 1'b0;
    test_reset();
    test_sub_single();
    test_two_limb();
    test_stall();
    test_len_zero();
    test_mid_reset();
    test_saturate();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xc_mp_arith_seq.md
Name: xc_mp_arith_seq

Overview:
- Sequencer for multi-precision add/subtract built on the XCrypto msub/madd limb primitive.
- Accepts one command (operation, limb count), pulls operand limb pairs least-significant first, and chains the borrow/carry bit between limbs.
- Emits one result limb per operand pair, then the final borrow/carry.
- Sits between a limb-fetch engine and a limb-writeback engine in the crypto accelerator path.

Parameters:
XLEN, 32, limb width in bits
MAX_LIMBS, 16, maximum limbs per command
LW, $clog2(MAX_LIMBS)+1, width of the limb count field

Ports:
g_clk  input  1  clock
g_resetn  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accept; high only in IDLE
cmd_op  input  1  0 = subtract (msub), 1 = add (madd)
cmd_len  input  LW  limb count, 0..MAX_LIMBS
opnd_valid  input  1  operand limb pair valid
opnd_ready  output  1  operand limb pair accept
opnd_a  input  XLEN  minuend/augend limb
opnd_b  input  XLEN  subtrahend/addend limb
res_valid  output  1  result limb valid
res_ready  input  1  result limb accept
res_data  output  XLEN  result limb
res_last  output  1  marks most-significant result limb
done_valid  output  1  one-cycle pulse: command complete
done_flag  output  1  final borrow (sub) or carry (add); valid with done_valid
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, g_resetn low): state=IDLE; all of res_valid, res_data, res_last, done_valid, done_flag, busy, opnd_ready = 0; cmd_ready = 1 after reset release. Internal carry = 0, count = 0. Reset mid-command abandons it with no done pulse.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - cmd handshake latches op and len, clears the carry and count.
  - len==0 -> DONE. The next cycle asserts done_valid with done_flag=0; no operands are requested.
  - len>0 -> RUN next cycle.
- RUN:
  - opnd_ready = !res_valid || res_ready. This is a single-entry output register with pass-through on a same-cycle drain.
- Operand handshake arithmetic, computed at XLEN+1 bits, zero-extended:
  - Subtract: r = a - b - carry. New carry = r[XLEN], where 1 = borrow.
  - Add: r = a + b + carry. New carry = r[XLEN].
  - res_data <= r[XLEN-1:0]; res_valid <= 1 next cycle (one-cycle latency).
  - res_last <= (count == len-1); count increments.
- On handshake of limb count==len-1 -> DRAIN.
- DRAIN: no operands accepted. On res_valid && res_ready -> DONE.
- DONE: done_valid=1 for exactly one cycle, done_flag=carry, then IDLE. cmd_ready is low during DONE.
- res_valid holds with data stable until res_ready. res_valid clears on handshake unless it is reloaded in the same cycle.
- cmd_valid while not IDLE: ignored (cmd_ready=0).
- Extra opnd_valid outside RUN: not accepted.
- Count never exceeds len. cmd_len > MAX_LIMBS saturates to MAX_LIMBS.
- Carry wraps correctly across all limbs, including all-ones inputs (0xFFFFFFFF + 0xFFFFFFFF + 1 = 0xFFFFFFFF, carry 1).
- Throughput: one limb per cycle when res_ready is held high.
- Total latency, command accept to done_valid: len + 2 cycles minimum.

Test Plan:
- 1-limb sub, a=5, b=3, res_ready=1 -> res_data=2, res_last=1; done_valid pulse with done_flag=0, exactly 3 cycles after cmd accept.
- 1-limb sub, a=0, b=1 -> res_data=0xFFFFFFFF, done_flag=1.
- 2-limb sub, a={hi 1, lo 0}, b={hi 0, lo 1} -> limb0=0xFFFFFFFF (borrow 1); limb1=0x00000000, res_last=1; done_flag=0.
- 2-limb add, a={0, 0xFFFFFFFF}, b={0, 1} -> limb0=0, limb1=1, done_flag=0. Repeat with hi limbs 0xFFFFFFFF each -> limb1=0xFFFFFFFF, done_flag=1.
- 4-limb sub with res_ready toggled 1/0 every cycle -> opnd_ready low while res_valid && !res_ready; res_data stable while stalled; all 4 limbs correct, in order, no drops or duplicates.
- cmd_len=0 -> done_valid with flag 0 one cycle after accept, no opnd_ready. Separately, assert g_resetn low after 2 of 4 limbs -> all outputs 0 immediately, no done_valid; a following 1-limb command completes normally with carry starting at 0.
